id_auth_ctrl: RTL and testbench

Parametrised player-ID authentication controller.
- Collects a multi-digit code, one digit per password-button press, from the switch bank.
- Searches a constant ID table one entry per cycle. On a match, raises matched_id and drives the player's address to the game controller.
- Counts failed attempts and locks entry out after too many. Logout from the game controller returns the block to entry.

---
 rtl/id_auth_pkg.sv | 27 ++
 rtl/id_table_rom.sv | 23 ++
 rtl/id_auth_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_id_auth_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_auth_pkg.sv
// Shared types and constants for the player-ID authentication controller.
// Holds the controller state enum, the default four-player ID table and a
// constant-evaluable ceil(log2) helper used to size counters and ports.
package id_auth_pkg;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    SEARCH = 2'd1,
    AUTH   = 2'd2,
    LOCKED = 2'd3
  } authState_e;

  // Entry p lives at bits [p*16 +: 16]; first-entered digit is the top nibble.
  // P0=0,3,7,4  P1=1,2,3,4  P2=9,9,9,9  P3=5,0,5,0
  localparam logic [63:0] DEFAULT_ID_TABLE = {16'h5050, 16'h9999, 16'h1234, 16'h0374};

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_table_rom.sv
// Constant ID table read port: returns the stored code for one player index.
// Kept as its own block so a RAM-backed table can replace it later.
module id_table_rom
  import id_auth_pkg::*;
#(
  parameter int CODE_W      = 16,
  parameter int NUM_PLAYERS = 4,
  parameter int IDX_W       = 2,
  parameter logic [NUM_PLAYERS*CODE_W-1:0] ID_TABLE = DEFAULT_ID_TABLE
) (
  input  logic [IDX_W-1:0]  i_idx,
  output logic [CODE_W-1:0] o_code
);

  // Select the table slice whose index matches; unused indices read as zero.
  always_comb begin
    o_code = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (i_idx == IDX_W'(p)) o_code = ID_TABLE[p*CODE_W +: CODE_W];
    end
  end

endmodule

// File: rtl/id_auth_ctrl.sv
// Player-ID authentication controller.
// Collects CODE_LEN digits from the switch bank (one per button press), then
// walks the ID table one entry per cycle looking for the lowest matching
// player. Consecutive misses lead to a timed lockout; logout from the game
// controller returns to digit entry.
// Optional build macro ENTRY_TIMEOUT_EN: discards a partial entry after
// TIMEOUT_CYCLES idle cycles. Without it a partial entry is held forever.
module id_auth_ctrl
  import id_auth_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int NUM_PLAYERS    = 4,
  parameter int ADDR_W         = 5,
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [NUM_PLAYERS*CODE_LEN*DIGIT_W-1:0] ID_TABLE = DEFAULT_ID_TABLE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIGIT_W-1:0]              i_switches,
  input  logic                            i_password_button,
  input  logic                            i_logout_cmd,
  output logic                            o_matched_id,
  output logic [ADDR_W-1:0]               o_player_address,
  output logic [clog2(CODE_LEN+1)-1:0]    o_digit_count,
  output logic                            o_auth_fail,
  output logic                            o_locked
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W  = clog2(CODE_LEN + 1);
  localparam int IDX_W  = (NUM_PLAYERS > 1) ? clog2(NUM_PLAYERS) : 1;
  localparam int FAIL_W = clog2(MAX_FAILS + 1);
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? clog2(LOCK_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(CODE_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_PLAYERS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);

`ifdef ENTRY_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] r_idleCnt;
`endif

  authState_e        r_state;
  logic              r_btnQ;
  logic [CODE_W-1:0] r_entry;
  logic [IDX_W-1:0]  r_idx;
  logic [FAIL_W-1:0] r_failCnt;
  logic [LOCK_W-1:0] r_lockTimer;

  logic              w_press;
  logic [CODE_W-1:0] w_romCode;
  logic              w_match;
  logic [FAIL_W-1:0] w_failNext;

  assign w_press    = i_password_button & ~r_btnQ;
  assign w_match    = (r_entry == w_romCode);
  assign w_failNext = r_failCnt + FAIL_W'(1);

  id_table_rom #(
    .CODE_W      (CODE_W),
    .NUM_PLAYERS (NUM_PLAYERS),
    .IDX_W       (IDX_W),
    .ID_TABLE    (ID_TABLE)
  ) u_rom (
    .i_idx  (r_idx),
    .o_code (w_romCode)
  );

  // Remember last cycle's button level so a held button yields a single press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btnQ <= 1'b0;
    else     r_btnQ <= i_password_button;
  end

  // Main controller: entry, table search, authenticated hold and lockout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ENTRY;
      r_entry          <= '0;
      r_idx            <= '0;
      r_failCnt        <= '0;
      r_lockTimer      <= '0;
      o_matched_id     <= 1'b0;
      o_player_address <= '0;
      o_digit_count    <= '0;
      o_auth_fail      <= 1'b0;
      o_locked         <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      r_idleCnt        <= '0;
`endif
    end else begin
      o_auth_fail <= 1'b0;
      case (r_state)
        ENTRY: begin
          if (i_logout_cmd) begin
            o_digit_count <= '0;
            r_entry       <= '0;
`ifdef ENTRY_TIMEOUT_EN
            r_idleCnt     <= '0;
`endif
          end else if (w_press) begin
            r_entry <= (r_entry << DIGIT_W) | CODE_W'(i_switches);
`ifdef ENTRY_TIMEOUT_EN
            r_idleCnt <= '0;
`endif
            if (o_digit_count == LAST_DIGIT) begin
              o_digit_count <= '0;
              r_idx         <= '0;
              r_state       <= SEARCH;
            end else begin
              o_digit_count <= o_digit_count + CNT_W'(1);
            end
          end
`ifdef ENTRY_TIMEOUT_EN
          else if (o_digit_count != '0) begin
            if (r_idleCnt == IDLE_LAST) begin
              o_digit_count <= '0;
              r_entry       <= '0;
              r_idleCnt     <= '0;
            end else begin
              r_idleCnt <= r_idleCnt + IDLE_W'(1);
            end
          end
`endif
        end

        SEARCH: begin
          if (i_logout_cmd) begin
            r_idx   <= '0;
            r_state <= ENTRY;
          end else if (w_match) begin
            o_matched_id     <= 1'b1;
            o_player_address <= ADDR_W'(r_idx);
            r_failCnt        <= '0;
            r_state          <= AUTH;
          end else if (r_idx == LAST_IDX) begin
            o_auth_fail <= 1'b1;
            r_idx       <= '0;
            if (w_failNext == FAIL_LIMIT) begin
              r_failCnt   <= w_failNext;
              o_locked    <= 1'b1;
              r_lockTimer <= '0;
              r_state     <= LOCKED;
            end else begin
              r_failCnt <= w_failNext;
              r_state   <= ENTRY;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        AUTH: begin
          if (i_logout_cmd) begin
            o_matched_id     <= 1'b0;
            o_player_address <= '0;
            r_state          <= ENTRY;
          end
        end

        LOCKED: begin
          if (r_lockTimer == LOCK_LAST) begin
            o_locked  <= 1'b0;
            r_failCnt <= '0;
            r_state   <= ENTRY;
          end else begin
            r_lockTimer <= r_lockTimer + LOCK_W'(1);
          end
        end

        default: r_state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_id_auth_ctrl.sv
// Self-checking bench for id_auth_ctrl (default parameters).
// Expected outputs come from a timeline model: entered digits in a queue, the
// search result and its arrival edge computed by scanning the table, and
// lockout expressed as an end-edge number. Honours ENTRY_TIMEOUT_EN.
module tb_id_auth_ctrl;

  localparam int CODE_LEN       = 4;
  localparam int NUM_PLAYERS    = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCK_CYCLES    = 16;
  localparam int TIMEOUT_CYCLES = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] switches = '0;
  logic       passwordButton = 1'b0;
  logic       logoutCmd = 1'b0;
  logic       matchedId;
  logic [4:0] playerAddress;
  logic [2:0] digitCount;
  logic       authFail;
  logic       locked;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  int idTable[NUM_PLAYERS][CODE_LEN] = '{'{0, 3, 7, 4}, '{1, 2, 3, 4}, '{9, 9, 9, 9}, '{5, 0, 5, 0}};

  bit expMatched;
  int expAddr;
  int expDigits;
  bit expFail;
  bit expLocked;
  int digits[$];
  int edgeNo;
  bit mPrevBtn;
  bit mAuth;
  int mFails;
  int mResultAt;
  int mResultIdx;
  int mLockEnd;
  int mIdle;

  id_auth_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_switches        (switches),
    .i_password_button (passwordButton),
    .i_logout_cmd      (logoutCmd),
    .o_matched_id      (matchedId),
    .o_player_address  (playerAddress),
    .o_digit_count     (digitCount),
    .o_auth_fail       (authFail),
    .o_locked          (locked)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== 32'(expected)) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    expMatched = 0; expAddr = 0; expDigits = 0; expFail = 0; expLocked = 0;
    digits.delete();
    mPrevBtn = 0; mAuth = 0; mFails = 0; mResultAt = 0; mResultIdx = -1;
    mLockEnd = 0; mIdle = 0;
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic modelStep(input int sw, input bit btn, input bit lo);
    bit press;
    bit same;
    press = btn && !mPrevBtn;
    mPrevBtn = btn;
    edgeNo++;
    expFail = 0;
    if (mAuth) begin
      if (lo) begin mAuth = 0; expMatched = 0; expAddr = 0; end
    end else if (mLockEnd != 0) begin
      if (edgeNo == mLockEnd) begin mLockEnd = 0; expLocked = 0; mFails = 0; end
    end else if (mResultAt != 0) begin
      if (lo) mResultAt = 0;
      else if (edgeNo == mResultAt) begin
        mResultAt = 0;
        if (mResultIdx >= 0) begin
          mAuth = 1; expMatched = 1; expAddr = mResultIdx; mFails = 0;
        end else begin
          expFail = 1;
          mFails++;
          if (mFails == MAX_FAILS) begin expLocked = 1; mLockEnd = edgeNo + LOCK_CYCLES; end
        end
      end
    end else begin
      if (lo) begin
        digits.delete(); mIdle = 0;
      end else if (press) begin
        digits.push_back(sw); mIdle = 0;
        if (digits.size() == CODE_LEN) begin
          mResultIdx = -1;
          for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            same = 1;
            for (int d = 0; d < CODE_LEN; d++) if (idTable[p][d] != digits[d]) same = 0;
            if (same) mResultIdx = p;
          end
          mResultAt = edgeNo + ((mResultIdx >= 0) ? mResultIdx + 1 : NUM_PLAYERS);
          digits.delete();
        end
      end
`ifdef ENTRY_TIMEOUT_EN
      else if (digits.size() > 0) begin
        mIdle++;
        if (mIdle == TIMEOUT_CYCLES) begin digits.delete(); mIdle = 0; end
      end
`endif
    end
    expDigits = digits.size();
  endtask

  // Compare every DUT output with the model once per cycle on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("matched_id", 32'(matchedId), int'(expMatched));
      checkOutput("player_address", 32'(playerAddress), expAddr);
      checkOutput("digit_count", 32'(digitCount), expDigits);
      checkOutput("auth_fail", 32'(authFail), int'(expFail));
      checkOutput("locked", 32'(locked), int'(expLocked));
    end
  end

  task automatic applyStimulus(input logic [3:0] sw, input logic btn, input logic lo);
    switches = sw; passwordButton = btn; logoutCmd = lo;
    @(posedge clk);
    #1;
    if (!rst) modelStep(int'(sw), btn, lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'd0, 1'b0, 1'b0);
  endtask

  task automatic enterDigit(input logic [3:0] d);
    applyStimulus(d, 1'b1, 1'b0);
    applyStimulus(d, 1'b0, 1'b0);
  endtask

  task automatic enterCode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    enterDigit(a); enterDigit(b); enterDigit(c); enterDigit(d);
  endtask

  task automatic logout();
    applyStimulus(4'd0, 1'b0, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_matched"}, 32'(matchedId), 0);
    checkOutput({tag, "_addr"}, 32'(playerAddress), 0);
    checkOutput({tag, "_digits"}, 32'(digitCount), 0);
    checkOutput({tag, "_fail"}, 32'(authFail), 0);
    checkOutput({tag, "_locked"}, 32'(locked), 0);
  endtask

  initial begin
    rst = 1'b1;
    edgeNo = 0;
    modelReset();
    checking = 1'b1;
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkAllZero("reset");
    applyStimulus(4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Player 0 matches at the first search slot.
    enterDigit(4'd0); enterDigit(4'd3);
    checkOutput("two_digits", 32'(digitCount), 2);
    enterDigit(4'd7); enterDigit(4'd4);
    checkOutput("p0_matched", 32'(matchedId), 1);
    checkOutput("p0_addr", 32'(playerAddress), 0);
    checkOutput("p0_digits", 32'(digitCount), 0);
    logout();
    checkOutput("p0_logout", 32'(matchedId), 0);

    // Player 3 matches at the last search slot, then logout and re-entry.
    enterCode(4'd5, 4'd0, 4'd5, 4'd0);
    idle(2);
    checkOutput("p3_not_yet", 32'(matchedId), 0);
    idle(1);
    checkOutput("p3_matched", 32'(matchedId), 1);
    checkOutput("p3_addr", 32'(playerAddress), 3);
    logout();
    checkOutput("p3_logout_m", 32'(matchedId), 0);
    checkOutput("p3_logout_a", 32'(playerAddress), 0);
    enterDigit(4'd1);
    checkOutput("reentry_digit", 32'(digitCount), 1);
    logout();
    checkOutput("entry_logout", 32'(digitCount), 0);

    // Three misses lead to lockout; inputs ignored while locked.
    for (int i = 0; i < 3; i++) begin
      enterCode(4'd1, 4'd1, 4'd1, 4'd1);
      idle(2);
      checkOutput("miss_early", 32'(authFail), 0);
      idle(1);
      checkOutput("miss_pulse", 32'(authFail), 1);
    end
    checkOutput("lock_set", 32'(locked), 1);
    enterCode(4'd1, 4'd2, 4'd3, 4'd4);
    logout();
    checkOutput("lock_digits", 32'(digitCount), 0);
    idle(6);
    checkOutput("lock_last", 32'(locked), 1);
    idle(1);
    checkOutput("lock_clear", 32'(locked), 0);
    enterCode(4'd1, 4'd2, 4'd3, 4'd4);
    idle(1);
    checkOutput("p1_matched", 32'(matchedId), 1);
    checkOutput("p1_addr", 32'(playerAddress), 1);
    logout();

    // Held button counts once; logout wins over a coincident press.
    for (int i = 0; i < 5; i++) applyStimulus(4'd7, 1'b1, 1'b0);
    applyStimulus(4'd7, 1'b0, 1'b0);
    checkOutput("held_once", 32'(digitCount), 1);
    applyStimulus(4'd2, 1'b1, 1'b1);
    checkOutput("logout_press", 32'(digitCount), 0);
    applyStimulus(4'd2, 1'b0, 1'b0);

    // Reset while searching for player 2 suppresses the match.
    enterCode(4'd9, 4'd9, 4'd9, 4'd9);
    rst = 1'b1;
    #1;
    modelReset();
    checkAllZero("rst_search");
    idle(3);
    rst = 1'b0;
    enterCode(4'd0, 4'd3, 4'd7, 4'd4);
    checkOutput("post_rst1_m", 32'(matchedId), 1);
    logout();

    // Reset while locked clears the lock immediately.
    for (int i = 0; i < 3; i++) begin
      enterCode(4'd2, 4'd2, 4'd2, 4'd2);
      idle(3);
    end
    idle(2);
    checkOutput("pre_rst_lock", 32'(locked), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_lock_now", 32'(locked), 0);
    modelReset();
    idle(2);
    rst = 1'b0;
    enterCode(4'd0, 4'd3, 4'd7, 4'd4);
    checkOutput("post_rst2_m", 32'(matchedId), 1);
    checkOutput("post_rst2_a", 32'(playerAddress), 0);
    logout();

    // Partial entry followed by a long idle gap.
    enterDigit(4'd9); enterDigit(4'd9);
    idle(70);
`ifdef ENTRY_TIMEOUT_EN
    checkOutput("timeout_clear", 32'(digitCount), 0);
    enterCode(4'd9, 4'd9, 4'd9, 4'd9);
`else
    checkOutput("partial_held", 32'(digitCount), 2);
    enterDigit(4'd9); enterDigit(4'd9);
`endif
    idle(1);
    checkOutput("p2_not_yet", 32'(matchedId), 0);
    idle(1);
    checkOutput("p2_matched", 32'(matchedId), 1);
    checkOutput("p2_addr", 32'(playerAddress), 2);
    logout();
    idle(3);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
